beam_command_applier: RTL

//  Array-side consumer of the 8D beam steering command stream (step indices + Q8.8 offsets + valid).

---
 rtl/beam_apply_pkg.sv | 36 +++
 rtl/beam_cmd_fifo.sv | 61 ++++++
 rtl/beam_command_applier.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/beam_apply_pkg.sv
// Shared types for the beam command applier: FSM states, the buffered command
// record and the boresight constant used after steering is switched off.
package beam_apply_pkg;

  localparam logic [3:0] BEAM_CENTER_STEP = 4'd8;
  localparam int         CMD_OFF_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_PRI = 3'd1,
    S_LOAD     = 3'd2,
    S_SWEEP    = 3'd3,
    S_SETTLE   = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0]           az_step;
    logic [3:0]           el_step;
    logic [CMD_OFF_W-1:0] az_off;
    logic [CMD_OFF_W-1:0] el_off;
  } beam_cmd_t;

  localparam beam_cmd_t BORESIGHT_CMD = '{
    az_step: BEAM_CENTER_STEP,
    el_step: BEAM_CENTER_STEP,
    az_off:  '0,
    el_off:  '0
  };

  // Signed distance of a step index from boresight.
  function automatic int step_delta(input logic [3:0] step);
    return int'(step) - int'(BEAM_CENTER_STEP);
  endfunction

endpackage

// File: rtl/beam_cmd_fifo.sv
// Small synchronous FIFO of beam commands with flush; a pop in the same cycle
// frees a slot so a push into a full FIFO is still accepted.
module beam_cmd_fifo
  import beam_apply_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  beam_cmd_t din,
  input  logic      pop,
  output beam_cmd_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_q, wr_d;
  logic [PTR_W:0] rd_q, rd_d;
  logic           pop_ok;
  logic           push_ok;
  beam_cmd_t      mem_q [DEPTH];

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                   (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok) & ~flush;
  assign dout    = mem_q[rd_q[PTR_W-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + 1'b1;
      if (pop_ok)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/beam_command_applier.sv
// Buffers beam steering commands, applies one per PRI boundary by sweeping
// per-element phase words onto the phase-shifter bus, then reports the settled beam.
module beam_command_applier
  import beam_apply_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int N_COL          = 8,
  parameter int N_ROW          = 8,
  parameter int PHASE_W        = 10,
  parameter int PHASE_PER_STEP = 23,
  parameter int FIFO_DEPTH     = 4,
  parameter int SETTLE_CYC     = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             apply_en,
  input  logic [3:0]                       cmd_az_step,
  input  logic [3:0]                       cmd_el_step,
  input  logic [DATA_WIDTH-1:0]            cmd_az_offset,
  input  logic [DATA_WIDTH-1:0]            cmd_el_offset,
  input  logic                             cmd_valid,
  input  logic                             pri_strobe,
  output logic [PHASE_W-1:0]               ph_word,
  output logic [$clog2(N_ROW*N_COL)-1:0]   ph_index,
  output logic                             ph_valid,
  input  logic                             ph_ready,
  output logic                             beam_applied,
  output logic [DATA_WIDTH-1:0]            applied_az_offset,
  output logic [DATA_WIDTH-1:0]            applied_el_offset,
  output logic                             busy,
  output logic [15:0]                      stat_drops,
  output logic [15:0]                      stat_applied
);

  localparam int N_ELEM = N_ROW * N_COL;
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int COL_W  = $clog2(N_COL);
  localparam int CNT_W  = $clog2(SETTLE_CYC + 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_ELEM - 1);
  localparam logic [COL_W-1:0] COL_LAST    = COL_W'(N_COL - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t                state_q, state_d;
  logic [PHASE_W-1:0]    az_inc_q, az_inc_d;
  logic [PHASE_W-1:0]    el_inc_q, el_inc_d;
  logic [PHASE_W-1:0]    col_acc_q, col_acc_d;
  logic [PHASE_W-1:0]    row_base_q, row_base_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      settle_q, settle_d;
  logic                  bore_pend_q, bore_pend_d;
  logic                  apply_en_q, apply_en_d;
  logic [15:0]           drops_q, drops_d;
  logic [15:0]           applied_q, applied_d;
  logic [CMD_OFF_W-1:0]  cur_az_off_q, cur_az_off_d;
  logic [CMD_OFF_W-1:0]  cur_el_off_q, cur_el_off_d;
  logic [DATA_WIDTH-1:0] app_az_q, app_az_d;
  logic [DATA_WIDTH-1:0] app_el_q, app_el_d;

  logic      apply_fall;
  logic      fifo_push;
  logic      fifo_pop;
  logic      fifo_full;
  logic      fifo_empty;
  logic      drop;
  beam_cmd_t fifo_din;
  beam_cmd_t fifo_dout;
  beam_cmd_t cmd_sel;

  // Per-element phase step for a step index, wrapped to the phase word width.
  function automatic logic [PHASE_W-1:0] phase_inc(input logic [3:0] step);
    return PHASE_W'(step_delta(step) * PHASE_PER_STEP);
  endfunction

  assign apply_en_d = apply_en;
  assign apply_fall = apply_en_q & ~apply_en;
  assign fifo_push  = cmd_valid & apply_en;
  assign drop       = fifo_push & fifo_full & ~fifo_pop;

  always_comb begin
    fifo_din         = '0;
    fifo_din.az_step = cmd_az_step;
    fifo_din.el_step = cmd_el_step;
    fifo_din.az_off  = CMD_OFF_W'(cmd_az_offset);
    fifo_din.el_off  = CMD_OFF_W'(cmd_el_offset);
  end

  beam_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (apply_fall),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    az_inc_d     = az_inc_q;
    el_inc_d     = el_inc_q;
    col_acc_d    = col_acc_q;
    row_base_d   = row_base_q;
    col_d        = col_q;
    idx_d        = idx_q;
    settle_d     = settle_q;
    bore_pend_d  = bore_pend_q | apply_fall;
    applied_d    = applied_q;
    cur_az_off_d = cur_az_off_q;
    cur_el_off_d = cur_el_off_q;
    app_az_d     = app_az_q;
    app_el_d     = app_el_q;
    fifo_pop     = 1'b0;
    cmd_sel      = fifo_dout;

    if (drop && drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
    else                             drops_d = drops_q;

    case (state_q)
      S_IDLE: begin
        if (bore_pend_q || !fifo_empty) state_d = S_WAIT_PRI;
      end
      S_WAIT_PRI: begin
        if (pri_strobe) state_d = S_LOAD;
      end
      S_LOAD: begin
        // A pending boresight beam takes precedence over anything queued later.
        if (bore_pend_q) begin
          cmd_sel     = BORESIGHT_CMD;
          bore_pend_d = apply_fall;
        end else begin
          fifo_pop = ~fifo_empty;
        end
        if (bore_pend_q || !fifo_empty) begin
          az_inc_d     = phase_inc(cmd_sel.az_step);
          el_inc_d     = phase_inc(cmd_sel.el_step);
          cur_az_off_d = cmd_sel.az_off;
          cur_el_off_d = cmd_sel.el_off;
          col_acc_d    = '0;
          row_base_d   = '0;
          col_d        = '0;
          idx_d        = '0;
          state_d      = S_SWEEP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWEEP: begin
        if (ph_ready) begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == COL_LAST) begin
            col_d      = '0;
            col_acc_d  = '0;
            row_base_d = row_base_q + el_inc_q;
          end else begin
            col_d     = col_q + COL_W'(1);
            col_acc_d = col_acc_q + az_inc_q;
          end
          if (idx_q == IDX_LAST) begin
            settle_d = '0;
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        // Report values change together with the beam_applied pulse.
        if (settle_q == SETTLE_LAST) begin
          state_d   = S_DONE;
          applied_d = applied_q + 16'd1;
          app_az_d  = DATA_WIDTH'(cur_az_off_q);
          app_el_d  = DATA_WIDTH'(cur_el_off_q);
        end else begin
          settle_d = settle_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      az_inc_q     <= '0;
      el_inc_q     <= '0;
      col_acc_q    <= '0;
      row_base_q   <= '0;
      col_q        <= '0;
      idx_q        <= '0;
      settle_q     <= '0;
      bore_pend_q  <= 1'b0;
      apply_en_q   <= 1'b0;
      drops_q      <= '0;
      applied_q    <= '0;
      cur_az_off_q <= '0;
      cur_el_off_q <= '0;
      app_az_q     <= '0;
      app_el_q     <= '0;
    end else begin
      state_q      <= state_d;
      az_inc_q     <= az_inc_d;
      el_inc_q     <= el_inc_d;
      col_acc_q    <= col_acc_d;
      row_base_q   <= row_base_d;
      col_q        <= col_d;
      idx_q        <= idx_d;
      settle_q     <= settle_d;
      bore_pend_q  <= bore_pend_d;
      apply_en_q   <= apply_en_d;
      drops_q      <= drops_d;
      applied_q    <= applied_d;
      cur_az_off_q <= cur_az_off_d;
      cur_el_off_q <= cur_el_off_d;
      app_az_q     <= app_az_d;
      app_el_q     <= app_el_d;
    end
  end

  assign ph_valid          = (state_q == S_SWEEP);
  assign ph_word           = ph_valid ? (row_base_q + col_acc_q) : '0;
  assign ph_index          = ph_valid ? idx_q : '0;
  assign beam_applied      = (state_q == S_DONE);
  assign busy              = state_q inside {S_LOAD, S_SWEEP, S_SETTLE, S_DONE};
  assign applied_az_offset = app_az_q;
  assign applied_el_offset = app_el_q;
  assign stat_drops        = drops_q;
  assign stat_applied      = applied_q;

endmodule
